// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write store buffer between the CPU data port and the
// data memory. Stores become word address + byte enables, queue in a small FIFO
// and drain to the DM one per cycle whenever no load owns the DM address port.
// Loads read the DM combinationally with buffered bytes forwarded on top.
// Optional feature: define SB_COALESCE_EN to merge a store into the tail-most
// entry when it targets the same word.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [1:0]    cpu_choice,
  output logic          cpu_stall,
  output logic [31:0]   cpu_rdata,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic [3:0]    dm_be,
  input  logic [31:0]   dm_dout,
  output logic [2:0]    sb_count,
  output logic          sb_empty
);

  localparam int         PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] FULL = 3'(DEPTH);

  logic          entry_valid [DEPTH];
  logic [AW-1:0] entry_waddr [DEPTH];
  logic [3:0]    entry_be    [DEPTH];
  logic [31:0]   entry_data  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] last;
  logic [PW-1:0] fwd_idx;
  logic [2:0]    count;

  logic [AW-1:0] new_waddr;
  logic [3:0]    new_be;
  logic [31:0]   new_data;
  logic          drain;
  logic          coalesce_hit;
  logic          push;
  logic          merge;
  logic          unused_addr_bits;

  assign new_waddr        = cpu_addr[AW+1:2];
  assign unused_addr_bits = ^cpu_addr[31:AW+2];
  assign last             = tail - PW'(1);

  // Shift store data onto its byte lanes and build the matching enables
  always_comb begin
    new_be   = 4'b1111;
    new_data = cpu_wdata;
    case (cpu_choice)
      2'b01: begin
        new_be   = cpu_addr[1] ? 4'b1100 : 4'b0011;
        new_data = cpu_addr[1] ? {cpu_wdata[15:0], 16'h0000} : {16'h0000, cpu_wdata[15:0]};
      end
      2'b10: begin
        new_be   = 4'b0001 << cpu_addr[1:0];
        new_data = {24'h000000, cpu_wdata[7:0]} << {cpu_addr[1:0], 3'b000};
      end
      default: ;
    endcase
  end

  // A load owns the DM address port, so draining only happens on non-load cycles
  assign drain = (count != 3'd0) && !cpu_re;

`ifdef SB_COALESCE_EN
  // Merge into the newest entry unless that entry is the head leaving this cycle
  assign coalesce_hit = cpu_we && (count != 3'd0) && entry_valid[last] &&
                        (entry_waddr[last] == new_waddr) &&
                        !(drain && (count == 3'd1));
`else
  assign coalesce_hit = 1'b0;
`endif

  // A full buffer stalls even if the head pops this cycle; acceptance waits one cycle
  assign cpu_stall = cpu_we && (count == FULL) && !coalesce_hit;
  assign push      = cpu_we && !cpu_stall && !coalesce_hit;
  assign merge     = cpu_we && coalesce_hit;

  // Forward buffered bytes over DM data, walking oldest to newest so newest wins
  always_comb begin
    cpu_rdata = dm_dout;
    fwd_idx   = head;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PW'(k);
      if (entry_valid[fwd_idx] && (entry_waddr[fwd_idx] == new_waddr)) begin
        for (int b = 0; b < 4; b++) begin
          if (entry_be[fwd_idx][b]) cpu_rdata[8*b +: 8] = entry_data[fwd_idx][8*b +: 8];
        end
      end
    end
  end

  assign dm_we    = drain;
  assign dm_addr  = cpu_re ? new_waddr : entry_waddr[head];
  assign dm_din   = entry_data[head];
  assign dm_be    = drain ? entry_be[head] : 4'b0000;
  assign sb_count = count;
  assign sb_empty = (count == 3'd0);

  // FIFO storage, pointers and occupancy; reset drops every pending store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_valid[i] <= 1'b0;
        entry_waddr[i] <= '0;
        entry_be[i]    <= 4'b0000;
        entry_data[i]  <= 32'h0;
      end
    end else begin
      if (push) begin
        entry_valid[tail] <= 1'b1;
        entry_waddr[tail] <= new_waddr;
        entry_be[tail]    <= new_be;
        entry_data[tail]  <= new_data;
        tail              <= tail + PW'(1);
      end
      if (merge) begin
        entry_be[last] <= entry_be[last] | new_be;
        for (int b = 0; b < 4; b++) begin
          if (new_be[b]) entry_data[last][8*b +: 8] <= new_data[8*b +: 8];
        end
      end
      if (drain) begin
        entry_valid[head] <= 1'b0;
        head              <= head + PW'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
